// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ producers, bursts of up to MAX_BURST beats.
// Latency: 1 cycle from request in IDLE to first accept, 1 cycle from accept to fifo_wr_en, 1 beat per cycle in a burst.
// Backpressure: req_ready is dropped combinationally while the FIFO is full, or almostfull with a write still in flight.
//
// Ports:
//   clk, rst_n              clock (posedge) and asynchronous active-low reset
//   req_valid/req_data      per-requester beat valid and flattened data (requester i at [i*FIFO_WIDTH +: FIFO_WIDTH])
//   req_ready               combinational accept, at most one bit high, only for the grant holder
//   fifo_full/almostfull    FIFO fill flags used for throttling
//   fifo_wr_ack             FIFO write acknowledge, expected one cycle after each fifo_wr_en
//   fifo_wr_en/data_in      registered FIFO write port
//   grant_valid/grant_id    burst in progress and its owner
//   drop_err                sticky flag: an expected wr_ack never arrived
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          drop_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                  r_state;
    logic [IDW-1:0]          r_rr_ptr;
    logic [BCW-1:0]          r_beat_cnt;
    logic                    r_ack_exp;
    logic                    r_wr_en;
    logic [FIFO_WIDTH-1:0]   r_data;
    logic                    r_grant_valid;
    logic [IDW-1:0]          r_grant_id;
    logic                    r_drop_err;

    logic                    w_can_issue;
    logic                    w_gnt_vld;
    logic                    w_accept;
    logic [FIFO_WIDTH-1:0]   w_gnt_dat;
    logic [BCW-1:0]          w_beat_nxt;
    logic                    w_pick_vld;
    logic [IDW-1:0]          w_pick_id;
    logic [IDW-1:0]          w_ptr_nxt;

    // Index 'off' positions past 'base', wrapping at NUM_REQ (which need not be a power of two).
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // A write sitting in r_wr_en lands next edge; if the FIFO is one short of full
    // that write fills it, so a further accept now would overflow. Reads are not
    // credited, which only costs an occasional bubble.
    assign w_can_issue = !fifo_full && !(fifo_almostfull && r_wr_en);

    assign w_gnt_vld  = req_valid[r_grant_id];
    assign w_gnt_dat  = req_data[r_grant_id*FIFO_WIDTH +: FIFO_WIDTH];
    assign w_accept   = (r_state == ST_BURST) && w_gnt_vld && w_can_issue;
    assign w_beat_nxt = r_beat_cnt + BCW'(1);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    // Scan from the far end back toward rr_ptr so the closest valid requester
    // to rr_ptr is the last one written and therefore wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(r_rr_ptr, k)]) begin
                w_pick_vld = 1'b1;
                w_pick_id  = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_ptr_nxt = (w_pick_id == LAST_ID) ? '0 : w_pick_id + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
            r_ack_exp     <= 1'b0;
            r_wr_en       <= 1'b0;
            r_data        <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_drop_err    <= 1'b0;
        end else begin
            // The FIFO acks the cycle after it samples wr_en; unexpected acks are ignored.
            r_ack_exp <= r_wr_en;
            if (r_ack_exp && !fifo_wr_ack) begin
                r_drop_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_wr_en <= 1'b0;
                    if (w_pick_vld) begin
                        r_state       <= ST_BURST;
                        r_grant_id    <= w_pick_id;
                        r_grant_valid <= 1'b1;
                        r_beat_cnt    <= '0;
                        r_rr_ptr      <= w_ptr_nxt;
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        r_wr_en    <= 1'b1;
                        r_data     <= w_gnt_dat;
                        r_beat_cnt <= w_beat_nxt;
                        if (w_beat_nxt == BURST_LAST) begin
                            r_state       <= ST_IDLE;
                            r_grant_valid <= 1'b0;
                        end
                    end else begin
                        // Data holds; a stall (valid but throttled) keeps the grant.
                        r_wr_en <= 1'b0;
                        if (!w_gnt_vld) begin
                            r_state       <= ST_IDLE;
                            r_grant_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_wr_en       <= 1'b0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_data_in = r_data;
    assign grant_valid  = r_grant_valid;
    assign grant_id     = r_grant_id;
    assign drop_err     = r_drop_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural FIFO (depth 8), random and directed requesters, per-cycle reference compare.
// Latency: model predicts outputs one cycle ahead from the arbitration rules.
// Backpressure: FIFO fill level comes from the bench FIFO model, with optional reads.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int MAXB  = 4;
    localparam int DEPTH = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_almostfull;
    logic           fifo_wr_ack;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           drop_err;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MAXB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id),
        .drop_err        (drop_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural FIFO ----------------
    int   f_cnt;
    int   preload = 0;
    logic fifo_rd = 1'b0;
    logic ack_kill = 1'b0;
    logic ovf;

    assign fifo_full       = (f_cnt == DEPTH);
    assign fifo_almostfull = (f_cnt == DEPTH - 1);

    always @(posedge clk or negedge rst_n) begin
        bit wr_ok, rd_ok;
        if (!rst_n) begin
            f_cnt       <= preload;
            fifo_wr_ack <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            rd_ok = fifo_rd && (f_cnt > 0);
            wr_ok = fifo_wr_en && ((f_cnt < DEPTH) || rd_ok);
            f_cnt       <= f_cnt + int'(wr_ok) - int'(rd_ok);
            fifo_wr_ack <= wr_ok && !ack_kill;
            if (fifo_wr_en && !wr_ok) ovf <= 1'b1;
        end
    end

    // ---------------- requester driver ----------------
    // mode 0: idle, 1: all valid, 2: req1 offers 6 beats, 3: req0 streams, 4: random
    int       mode = 0;
    int       cnt [N];
    logic [N-1:0] acc = '0;

    initial begin
        req_valid = '0;
        req_data  = '0;
        foreach (cnt[i]) cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) cnt[i] = 0;
                else if (acc[i]) cnt[i]++;
            end
            case (mode)
                1: req_valid = '1;
                2: req_valid = (cnt[1] < 6) ? 4'b0010 : 4'b0000;
                3: req_valid = 4'b0001;
                4: begin
                    for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
                    fifo_rd = $urandom_range(0, 1) != 0;
                end
                default: req_valid = '0;
            endcase
            for (int i = 0; i < N; i++)
                req_data[i*W +: W] = {4'(i), 4'h0, 8'(160 + cnt[i])};
        end
    end

    // ---------------- reference model + compare ----------------
    int         m_owner;   // -1 when no grant is held
    int         m_gid;
    int         m_ptr;
    int         m_beats;
    bit         m_wr;
    logic [W-1:0] m_data;
    bit         m_ack_exp;
    bit         m_drop;
    int         cyc = 0;
    logic [W-1:0] wdat[$];
    int         wcyc[$];

    always @(negedge clk) begin
        bit can;
        logic [N-1:0] exp_rdy;
        bit n_drop;
        cyc++;
        if (!rst_n) begin
            chk("rst_wr_en", fifo_wr_en, 0);
            chk("rst_data", fifo_data_in, 0);
            chk("rst_grant_valid", grant_valid, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_drop_err", drop_err, 0);
            chk("rst_req_ready", req_ready, 0);
            m_owner = -1; m_gid = 0; m_ptr = 0; m_beats = 0;
            m_wr = 0; m_data = '0; m_ack_exp = 0; m_drop = 0;
            acc = '0;
        end else begin
            chk("wr_en", fifo_wr_en, m_wr);
            chk("data_in", fifo_data_in, m_data);
            chk("grant_valid", grant_valid, m_owner >= 0);
            chk("grant_id", grant_id, m_gid);
            chk("drop_err", drop_err, m_drop);
            can = !fifo_full && !(fifo_almostfull && m_wr);
            exp_rdy = '0;
            if (m_owner >= 0 && req_valid[m_owner] && can) exp_rdy[m_owner] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("ready_onehot", $countones(req_ready) <= 1, 1);
            acc = req_valid & req_ready;
            if (fifo_wr_en) begin
                wdat.push_back(fifo_data_in);
                wcyc.push_back(cyc);
            end
            // next-cycle prediction
            n_drop    = m_drop || (m_ack_exp && !fifo_wr_ack);
            m_ack_exp = m_wr;
            if (m_owner < 0) begin
                m_wr = 0;
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_gid   = m_owner;
                        m_beats = 0;
                    end
                end
                if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            end else if (exp_rdy != 0) begin
                m_wr   = 1;
                m_data = req_data[m_owner*W +: W];
                m_beats++;
                if (m_beats == MAXB) m_owner = -1;
            end else begin
                m_wr = 0;
                if (!req_valid[m_owner]) m_owner = -1;
            end
            m_drop = n_drop;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        wdat.delete();
        wcyc.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- directed phases ----------------
    initial begin
        int  t;
        bool_seen: begin end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset mid-burst: wait for requester 2 writing, then drop rst_n between edges.
        fifo_rd = 1'b1;
        mode    = 1;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!(grant_valid && grant_id == 2 && fifo_wr_en) && t < 200);
        chk("timeout_midburst", t < 200, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", fifo_wr_en, 0);
        chk("async_rst_data", fifo_data_in, 0);
        chk("async_rst_grant_valid", grant_valid, 0);
        chk("async_rst_grant_id", grant_id, 0);
        chk("async_rst_drop_err", drop_err, 0);
        chk("async_rst_req_ready", req_ready, 0);
        wdat.delete();
        wcyc.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Round-robin from rr_ptr=0: 0,1,2,3,0 with 4 writes each.
        t = 0;
        while (wdat.size() < 20 && t < 300) begin @(negedge clk); t++; end
        chk("timeout_rr", t < 300, 1);
        for (int k = 0; k < 20 && k < wdat.size(); k++)
            chk($sformatf("rr_write%0d_owner", k), wdat[k][15:12], (k / 4) % 4);
        mode = 0;
        repeat (10) @(posedge clk);

        // Single requester 1, six beats.
        do_reset();
        mode = 2;
        t = 0;
        while (wdat.size() < 6 && t < 100) begin @(negedge clk); t++; end
        chk("timeout_single", t < 100, 1);
        repeat (5) @(negedge clk);
        chk("single_count", wdat.size(), 6);
        if (wdat.size() >= 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("single_data%0d", k), wdat[k], 16'h10A0 + k);
            chk("single_b2b_1", wcyc[1] - wcyc[0], 1);
            chk("single_b2b_3", wcyc[3] - wcyc[2], 1);
            chk("single_gap", wcyc[4] - wcyc[3], 2);
            chk("single_b2b_5", wcyc[5] - wcyc[4], 1);
        end
        chk("single_grant_id", grant_id, 1);
        chk("single_drop_err", drop_err, 0);
        mode = 0;

        // Full throttle: no reads, requester 0 streams into an empty depth-8 FIFO.
        fifo_rd = 1'b0;
        do_reset();
        mode = 3;
        repeat (40) @(negedge clk);
        #1;
        chk("throttle_writes", wdat.size(), 8);
        chk("throttle_full", fifo_full, 1);
        chk("throttle_ready", req_ready, 0);
        chk("throttle_no_overflow", ovf, 0);
        mode = 0;

        // Almostfull with a write in flight, FIFO preloaded with 5 entries.
        preload = 5;
        do_reset();
        mode = 3;
        begin
            bit seen6, seen7;
            seen6 = 0; seen7 = 0;
            repeat (12) begin
                @(negedge clk);
                #1;
                if (!seen6 && f_cnt == 6 && fifo_wr_en) begin
                    seen6 = 1;
                    chk("af_cnt6_accept", req_ready, 4'b0001);
                end
                if (!seen7 && fifo_almostfull && fifo_wr_en) begin
                    seen7 = 1;
                    chk("af_inflight_block", req_ready, 0);
                end
            end
            chk("af_seen_cnt6", seen6, 1);
            chk("af_seen_inflight", seen7, 1);
        end
        chk("af_writes", wdat.size(), 3);
        chk("af_no_overflow", ovf, 0);
        mode    = 0;
        preload = 0;

        // Ack fault: suppress the ack following one write.
        fifo_rd = 1'b1;
        do_reset();
        mode = 1;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!fifo_wr_en && t < 50);
        chk("timeout_ack", t < 50, 1);
        ack_kill = 1'b1;
        @(posedge clk);
        #2 ack_kill = 1'b0;
        @(negedge clk);
        chk("ack_drop_pre", drop_err, 0);
        @(negedge clk);
        chk("ack_drop_set", drop_err, 1);
        repeat (5) @(negedge clk);
        chk("ack_drop_sticky", drop_err, 1);
        #2 rst_n = 1'b0;
        #1 chk("ack_drop_cleared", drop_err, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Random traffic with random FIFO reads.
        mode = 4;
        repeat (3000) @(posedge clk);
        mode = 0;
        fifo_rd = 1'b1;
        repeat (10) @(negedge clk);
        chk("random_no_overflow", ovf, 0);
        chk("random_drop_err", drop_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers.
- Grants the FIFO to one requester at a time for bursts of up to MAX_BURST beats.
- Drives the FIFO's wr_en and data_in from registered outputs, and throttles on the FIFO's full and almostfull flags so the FIFO never overflows.
- Checks the FIFO's wr_ack against every issued write and flags any mismatch.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FIFO_WIDTH, 16, data width; must match the FIFO.
- MAX_BURST, 4, maximum beats accepted per grant (1..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat-valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  flattened data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  NUM_REQ  combinational accept; a beat transfers when req_valid[i] && req_ready[i].
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO almostfull flag (count == depth-1).
- fifo_wr_ack  in  1  FIFO write acknowledge.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_data_in  out  FIFO_WIDTH  registered FIFO write data.
- grant_valid  out  1  high while in BURST.
- grant_id  out  $clog2(NUM_REQ)  current grant holder.
- drop_err  out  1  sticky: an expected wr_ack was missing.

Behaviour:
- Reset (async, rst_n low), all outputs 0 immediately:
  - state=IDLE, rr_ptr=0, beat_cnt=0, ack_exp=0.
  - fifo_wr_en=0, fifo_data_in=0, grant_valid=0, grant_id=0, drop_err=0.
  - req_ready=0.
- Reset mid-burst: the burst is abandoned. A beat accepted in the reset cycle is lost; the requester must not assume delivery.
- can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en).
  - The second term covers the write already in flight in the output register. Reads are ignored, which is conservative.
- State IDLE:
  - req_ready=0.
  - If any req_valid, pick the first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On a pick, next cycle: state=BURST, grant_id=winner, grant_valid=1, beat_cnt=0, rr_ptr=(winner+1) mod NUM_REQ.
  - No req_valid: stay in IDLE.
- State BURST:
  - req_ready[grant_id] = req_valid[grant_id] && can_issue; all other ready bits are 0.
  - On an accept, next cycle: fifo_wr_en=1, fifo_data_in=that requester's data, beat_cnt+1.
  - Otherwise fifo_wr_en=0 and fifo_data_in holds its value.
  - Stall (valid high, can_issue low): stay in BURST, beat_cnt frozen.
  - Exit to IDLE next cycle, with grant_valid=0, when either:
    - an accept makes beat_cnt reach MAX_BURST, or
    - req_valid[grant_id]=0.
- Latency:
  - Request in IDLE to first accept: 1 cycle.
  - Accept to fifo_wr_en: 1 cycle.
  - Back-to-back beats within a burst: 1 per cycle.
  - Minimum 1 IDLE cycle between bursts.
- Fairness:
  - rr_ptr always points past the last winner.
  - With all requesters valid and the FIFO never full, grants rotate 0,1,2,3,0,...
- Ack check:
  - The FIFO acks one cycle after sampling wr_en, so ack_exp is set to fifo_wr_en each cycle.
  - If ack_exp && !fifo_wr_ack, drop_err goes to 1 and stays until reset.
  - An unexpected ack (ack without ack_exp) is ignored.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr wraps to 0 after NUM_REQ-1, including non-power-of-2 NUM_REQ.
- Invariants:
  - At most one req_ready bit is high.
  - fifo_wr_en is never 1 in a cycle where fifo_full was 1 at the preceding edge, except when a read freed space.
  - The FIFO overflow flag never asserts.

Test Plan:
- Reset: rst_n low mid-burst with fifo_wr_en=1 -> all outputs 0 in the same cycle; after release, state IDLE and rr_ptr=0.
- Single requester: req_valid=4'b0010, data 0xA0..0xA5 offered continuously, MAX_BURST=4 ->
  - grant_id=1;
  - fifo_data_in sequence A0,A1,A2,A3, one IDLE gap, then A4,A5;
  - drop_err=0.
- Round-robin: all 4 valid, FIFO never full -> grant order 0,1,2,3,0, each burst exactly 4 fifo_wr_en pulses.
- Full throttle: FIFO depth 8 with no reads, requester 0 streaming -> exactly 8 writes accepted, then req_ready=0 while fifo_full=1, and FIFO overflow never asserts.
- Almostfull in flight: count=6 and a write accepted -> the next beat is still accepted (almostfull low); once almostfull is high with fifo_wr_en=1, req_ready=0 for that cycle.
- Ack fault: force fifo_wr_ack=0 on the cycle after one fifo_wr_en -> drop_err=1 on the next edge and stays 1 until rst_n low.
